// File: rtl/nyan_keys_pkg.sv
// nyan_keys_pkg: constants, event record layout and helper functions shared
// by the key event queue and its FIFO.
package nyan_keys_pkg;

  // Default number of debounced key inputs on the keyboard matrix.
  localparam int KEYS_DEFAULT = 61;

  // Default event FIFO depth (power of two, at least 2).
  localparam int DEPTH_DEFAULT = 16;

  // Key index width for the default keyboard.
  localparam int KIDX_W_DEFAULT = $clog2(KEYS_DEFAULT);

  // Event record layout, most significant field first: {press, key index}.
  // The top level builds the same layout by concatenation so that a
  // non-default KEYS still produces the {press, key} ordering.
  typedef struct packed {
    logic                      press;
    logic [KIDX_W_DEFAULT-1:0] key;
  } key_evt_t;

  // Key index width; a single-key build still gets a one-bit index.
  function automatic int kidx_width(input int keys);
    return (keys > 1) ? $clog2(keys) : 1;
  endfunction

  // Width of one event record: press flag plus key index.
  function automatic int evt_width(input int kidx_w);
    return kidx_w + 1;
  endfunction

  // Level a key shows when it is not pressed.
  function automatic logic released_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// key_evt_fifo: first-word-fall-through FIFO for key events. The head entry
// is presented combinationally while the FIFO is non-empty and reads as zero
// when empty. Pushes into a full FIFO and pops from an empty one are ignored.
module key_evt_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  // Fullness and emptiness come from the registered count only, so a pop in
  // the same cycle never makes room for a push.
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next-state pointers and occupancy; push+pop together keeps the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because empty entries are masked.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Head presentation: zero while empty so downstream never sees stale data.
  always_comb begin
    rd_data_o = '0;
    if (!empty_o) begin
      rd_data_o = mem_q[rd_ptr_q];
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/key_event_queue.sv
// key_event_queue: converts debounced per-key levels into press/release
// events. A round-robin scanner compares one key per cycle against the last
// state reported for it and queues any difference in an FWFT FIFO that the
// host drains with a valid/ready handshake.
module key_event_queue
  import nyan_keys_pkg::*;
#(
  parameter int KEYS       = KEYS_DEFAULT,
  parameter int DEPTH      = DEPTH_DEFAULT,
  parameter int ACTIVE_LOW = 1,
  localparam int KIDX_W    = kidx_width(KEYS),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [KEYS-1:0]   keys_i,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [KIDX_W-1:0] evt_key_o,
  output logic              evt_press_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              defer_o,
  input  logic              defer_clr_i
);

  localparam int                EVT_W    = evt_width(KIDX_W);
  localparam logic              REL_LVL  = released_level(ACTIVE_LOW != 0);
  localparam logic [KIDX_W-1:0] LAST_IDX = KIDX_W'(KEYS - 1);

  logic [KIDX_W-1:0] scan_idx_q, scan_idx_d;
  logic [KEYS-1:0]   reported_q, reported_d;
  logic              defer_q, defer_d;

  logic [KEYS-1:0]   diff_vec;
  logic              cur_lvl;
  logic              diff;
  logic              push;
  logic              pop;
  logic              push_press;
  logic              fifo_full;
  logic              fifo_empty;
  logic [EVT_W-1:0]  wr_evt;
  logic [EVT_W-1:0]  rd_evt;

  // Per-key mismatch between the live level and the last reported level.
  genvar gi;
  generate
    for (gi = 0; gi < KEYS; gi++) begin : g_diff
      assign diff_vec[gi] = keys_i[gi] ^ reported_q[gi];
    end
  endgenerate

  // Only the key under the scanner may generate an event this cycle; a key
  // that flips and flips back between visits is never seen, which is fine
  // because debounced activity is much slower than one sweep.
  assign cur_lvl    = keys_i[scan_idx_q];
  assign diff       = diff_vec[scan_idx_q];
  assign push       = diff && !fifo_full;
  assign push_press = (cur_lvl != REL_LVL);
  assign wr_evt     = {push_press, scan_idx_q};
  assign pop        = evt_valid_o && evt_ready_i;

  // Scanner, reported-state and deferral next-state logic. A deferred key
  // keeps its old reported level so the next sweep retries it.
  always_comb begin
    scan_idx_d = (scan_idx_q == LAST_IDX) ? '0 : scan_idx_q + KIDX_W'(1);
    reported_d = reported_q;
    defer_d    = defer_q;
    if (push) begin
      reported_d[scan_idx_q] = cur_lvl;
    end
    if (defer_clr_i) begin
      defer_d = 1'b0;
    end
    if (diff && fifo_full) begin
      defer_d = 1'b1;
    end
  end

  // Scanner, reported-state and deferral registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scan_idx_q <= '0;
      reported_q <= {KEYS{REL_LVL}};
      defer_q    <= 1'b0;
    end else begin
      scan_idx_q <= scan_idx_d;
      reported_q <= reported_d;
      defer_q    <= defer_d;
    end
  end

  key_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .push_i    (push),
    .wr_data_i (wr_evt),
    .pop_i     (pop),
    .rd_data_o (rd_evt),
    .count_o   (count_o),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign evt_valid_o = !fifo_empty;
  assign evt_press_o = rd_evt[EVT_W-1];
  assign evt_key_o   = rd_evt[KIDX_W-1:0];
  assign defer_o     = defer_q;

endmodule
